mode_pntr_logic: RTL and testbench

MODE_PNTR_LOGIC -- requirements
Module: mode_pntr_logic

---
 rtl/mode_pntr_logic_pkg.sv | 13 +
 rtl/mode_pntr_logic_if.sv | 37 +++
 rtl/mode_pntr_logic_flags.sv | 59 +++++
 rtl/mode_pntr_logic.sv | 123 ++++++++++++
 tb/tb_mode_pntr_logic.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/mode_pntr_logic_pkg.sv
// rtl/mode_pntr_logic_pkg.sv - shared mode enum and default geometry for the FIFO/LIFO pointer block
package pntr_pkg;

  typedef enum logic {
    MODE_FIFO = 1'b0,
    MODE_LIFO = 1'b1
  } mode_e;

  localparam int DEF_AWIDTH       = 4;
  localparam int DEF_ALMOST_FULL  = 12;
  localparam int DEF_ALMOST_EMPTY = 2;

endpackage

// File: rtl/mode_pntr_logic_if.sv
// rtl/mode_pntr_logic_if.sv - request/strobe/status bundle between a client and the pointer block
import pntr_pkg::*;

interface mode_pntr_logic_if #(
  parameter int AWIDTH = DEF_AWIDTH
);
  logic              mode_i;
  logic              flush_i;
  logic              wrreq_i;
  logic              rdreq_i;
  logic              err_clr_i;
  logic              wren_o;
  logic              rden_o;
  logic [AWIDTH-1:0] wrpntr_o;
  logic [AWIDTH-1:0] rdpntr_o;
  logic              empty_o;
  logic              full_o;
  logic              almost_empty_o;
  logic              almost_full_o;
  logic [AWIDTH:0]   usedw_o;
  logic              mode_o;
  logic              ovf_o;
  logic              udf_o;

  modport master (
    output mode_i, flush_i, wrreq_i, rdreq_i, err_clr_i,
    input  wren_o, rden_o, wrpntr_o, rdpntr_o, empty_o, full_o,
           almost_empty_o, almost_full_o, usedw_o, mode_o, ovf_o, udf_o
  );

  modport slave (
    input  mode_i, flush_i, wrreq_i, rdreq_i, err_clr_i,
    output wren_o, rden_o, wrpntr_o, rdpntr_o, empty_o, full_o,
           almost_empty_o, almost_full_o, usedw_o, mode_o, ovf_o, udf_o
  );

endinterface

// File: rtl/mode_pntr_logic_flags.sv
// rtl/mode_pntr_logic_flags.sv - word counter and registered status flags
// Flags are computed from the next-state count so they move in lockstep with usedw.
import pntr_pkg::*;

module pntr_flags #(
  parameter int AWIDTH       = DEF_AWIDTH,
  parameter int ALMOST_FULL  = DEF_ALMOST_FULL,
  parameter int ALMOST_EMPTY = DEF_ALMOST_EMPTY
) (
  input  logic            clk_i,
  input  logic            srst_i,
  input  logic            wren_i,
  input  logic            rden_i,
  input  logic            flush_i,
  output logic [AWIDTH:0] usedw_o,
  output logic            empty_o,
  output logic            full_o,
  output logic            almost_empty_o,
  output logic            almost_full_o
);

  localparam logic [AWIDTH:0] ONE     = 1;
  localparam logic [AWIDTH:0] DEPTH_W = {1'b1, {AWIDTH{1'b0}}};
  localparam logic [AWIDTH:0] AF_W    = (AWIDTH+1)'(ALMOST_FULL);
  localparam logic [AWIDTH:0] AE_W    = (AWIDTH+1)'(ALMOST_EMPTY);

  logic [AWIDTH:0] usedw_q;
  logic [AWIDTH:0] usedw_d;

  always_comb begin
    usedw_d = usedw_q;
    if (flush_i) begin
      usedw_d = '0;
    end else if (wren_i && !rden_i) begin
      usedw_d = usedw_q + ONE;
    end else if (rden_i && !wren_i) begin
      usedw_d = usedw_q - ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      usedw_q        <= '0;
      empty_o        <= 1'b1;
      full_o         <= 1'b0;
      almost_empty_o <= 1'b1;
      almost_full_o  <= 1'b0;
    end else begin
      usedw_q        <= usedw_d;
      empty_o        <= (usedw_d == '0);
      full_o         <= (usedw_d == DEPTH_W);
      almost_empty_o <= (usedw_d <= AE_W);
      almost_full_o  <= (usedw_d >= AF_W);
    end
  end

  assign usedw_o = usedw_q;

endmodule

// File: rtl/mode_pntr_logic.sv
// rtl/mode_pntr_logic.sv - FIFO/LIFO address generator for a single-port-pair RAM
// Mode may only change while the buffer is empty, so FIFO head/tail and LIFO top never alias live data.
import pntr_pkg::*;

module mode_pntr_logic #(
  parameter int AWIDTH       = DEF_AWIDTH,
  parameter int ALMOST_FULL  = DEF_ALMOST_FULL,
  parameter int ALMOST_EMPTY = DEF_ALMOST_EMPTY
) (
  input  logic               clk_i,
  input  logic               srst_i,
  mode_pntr_logic_if.slave   bus
);

  localparam logic [AWIDTH-1:0] ONE = 1;

  logic [AWIDTH-1:0] head_q, head_d;
  logic [AWIDTH-1:0] tail_q, tail_d;
  logic [AWIDTH-1:0] top_q, top_d;
  logic [AWIDTH-1:0] top_m1;
  mode_e             mode_q, mode_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              empty, full;
  logic              wren, rden;
  logic [AWIDTH-1:0] wrpntr, rdpntr;

  assign rden   = bus.rdreq_i & ~empty & ~bus.flush_i;
  assign wren   = bus.wrreq_i & ~bus.flush_i & (~full | rden);
  assign top_m1 = top_q - ONE;

  // Replace in LIFO mode targets the current top entry for both ports.
  always_comb begin
    wrpntr = tail_q;
    rdpntr = head_q;
    if (mode_q == MODE_LIFO) begin
      wrpntr = (wren && rden) ? top_m1 : top_q;
      rdpntr = top_m1;
    end
  end

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    top_d  = top_q;
    if (bus.flush_i) begin
      head_d = '0;
      tail_d = '0;
      top_d  = '0;
    end else if (mode_q == MODE_FIFO) begin
      if (wren) tail_d = tail_q + ONE;
      if (rden) head_d = head_q + ONE;
    end else begin
      if (wren && !rden) top_d = top_q + ONE;
      else if (rden && !wren) top_d = top_m1;
    end
  end

  always_comb begin
    mode_d = mode_q;
    if (bus.flush_i || (empty && !wren)) begin
      mode_d = mode_e'(bus.mode_i);
    end
  end

  // Error flags hold across a flush; setting beats clearing.
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (!bus.flush_i) begin
      if (bus.wrreq_i && !wren) ovf_d = 1'b1;
      else if (bus.err_clr_i)   ovf_d = 1'b0;
      if (bus.rdreq_i && !rden) udf_d = 1'b1;
      else if (bus.err_clr_i)   udf_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      head_q <= '0;
      tail_q <= '0;
      top_q  <= '0;
      mode_q <= MODE_FIFO;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      top_q  <= top_d;
      mode_q <= mode_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
    end
  end

  pntr_flags #(
    .AWIDTH       (AWIDTH),
    .ALMOST_FULL  (ALMOST_FULL),
    .ALMOST_EMPTY (ALMOST_EMPTY)
  ) u_flags (
    .clk_i          (clk_i),
    .srst_i         (srst_i),
    .wren_i         (wren),
    .rden_i         (rden),
    .flush_i        (bus.flush_i),
    .usedw_o        (bus.usedw_o),
    .empty_o        (empty),
    .full_o         (full),
    .almost_empty_o (bus.almost_empty_o),
    .almost_full_o  (bus.almost_full_o)
  );

  assign bus.wren_o   = wren;
  assign bus.rden_o   = rden;
  assign bus.wrpntr_o = wrpntr;
  assign bus.rdpntr_o = rdpntr;
  assign bus.empty_o  = empty;
  assign bus.full_o   = full;
  assign bus.mode_o   = mode_q;
  assign bus.ovf_o    = ovf_q;
  assign bus.udf_o    = udf_q;

endmodule

// File: tb/tb_mode_pntr_logic.sv
// tb/tb_mode_pntr_logic.sv - scoreboard bench: queue-of-words reference model plus a RAM image
import pntr_pkg::*;

module tb_mode_pntr_logic;

  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AE    = 2;

  logic clk = 1'b0;
  logic srst;
  always #5 clk = ~clk;

  mode_pntr_logic_if #(.AWIDTH(AW)) bus ();

  mode_pntr_logic #(
    .AWIDTH       (AW),
    .ALMOST_FULL  (AF),
    .ALMOST_EMPTY (AE)
  ) dut (
    .clk_i  (clk),
    .srst_i (srst),
    .bus    (bus)
  );

  typedef struct {
    bit wren, rden, chk_wp, chk_rp, chk_rd;
    int wp, rp, rdata, usedw;
    bit empty, full, ae, af, mode, ovf, udf;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  logic [7:0] mem [DEPTH];
  logic [7:0] wdata;
  always @(posedge clk) if (bus.wren_o) mem[bus.wrpntr_o] <= wdata;

  // Reference model: stored words as a queue; FIFO addresses are running totals mod DEPTH.
  int q[$];
  int fwr, frd;
  bit m_mode, m_ovf, m_udf;

  task automatic model_reset();
    q.delete();
    fwr = 0; frd = 0;
    m_mode = 0; m_ovf = 0; m_udf = 0;
  endtask

  task automatic cyc(input bit w, input bit r, input bit f, input bit m, input bit ec);
    exp_t e;
    int   cnt;
    bit   rd, wr;
    int   d;
    @(posedge clk); #1;
    d = int'($urandom_range(0, 255));
    bus.wrreq_i = w; bus.rdreq_i = r; bus.flush_i = f; bus.mode_i = m; bus.err_clr_i = ec;
    wdata = 8'(d);
    cnt = q.size();
    rd  = r && (cnt != 0) && !f;
    wr  = w && !f && ((cnt != DEPTH) || rd);
    e.wren = wr; e.rden = rd;
    e.usedw = cnt; e.empty = (cnt == 0); e.full = (cnt == DEPTH);
    e.ae = (cnt <= AE); e.af = (cnt >= AF);
    e.mode = m_mode; e.ovf = m_ovf; e.udf = m_udf;
    if (m_mode) begin
      e.chk_wp = wr; e.wp = ((wr && rd) ? cnt - 1 : cnt) % DEPTH;
      e.chk_rp = rd; e.rp = (cnt + DEPTH - 1) % DEPTH;
    end else begin
      e.chk_wp = 1; e.wp = fwr;
      e.chk_rp = 1; e.rp = frd;
    end
    e.chk_rd = rd;
    e.rdata  = rd ? (m_mode ? q[$] : q[0]) : 0;
    sb.push_back(e);
    if (f) begin
      q.delete(); fwr = 0; frd = 0; m_mode = m;
    end else begin
      if (!m_mode) begin
        if (rd) begin void'(q.pop_front()); frd = (frd + 1) % DEPTH; end
        if (wr) begin q.push_back(d);       fwr = (fwr + 1) % DEPTH; end
      end else begin
        if (rd) void'(q.pop_back());
        if (wr) q.push_back(d);
      end
      if (cnt == 0 && !wr) m_mode = m;
      if (w && !wr) m_ovf = 1; else if (ec) m_ovf = 0;
      if (r && !rd) m_udf = 1; else if (ec) m_udf = 0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    srst = 1'b1;
    bus.wrreq_i = 0; bus.rdreq_i = 0; bus.flush_i = 0; bus.mode_i = 0; bus.err_clr_i = 0;
    repeat (2) @(posedge clk);
    #1 srst = 1'b0;
    model_reset();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_vec++;
        chk("wren", 32'(bus.wren_o), 32'(e.wren));
        chk("rden", 32'(bus.rden_o), 32'(e.rden));
        if (e.chk_wp) chk("wrpntr", 32'(bus.wrpntr_o), 32'(e.wp));
        if (e.chk_rp) chk("rdpntr", 32'(bus.rdpntr_o), 32'(e.rp));
        if (e.chk_rd) chk("rdata", 32'(mem[bus.rdpntr_o]), 32'(e.rdata));
        chk("usedw", 32'(bus.usedw_o), 32'(e.usedw));
        chk("empty", 32'(bus.empty_o), 32'(e.empty));
        chk("full", 32'(bus.full_o), 32'(e.full));
        chk("almost_empty", 32'(bus.almost_empty_o), 32'(e.ae));
        chk("almost_full", 32'(bus.almost_full_o), 32'(e.af));
        chk("mode", 32'(bus.mode_o), 32'(e.mode));
        chk("ovf", 32'(bus.ovf_o), 32'(e.ovf));
        chk("udf", 32'(bus.udf_o), 32'(e.udf));
      end
    end
  end

  initial begin : stimulus
    int bias, rbias;
    bit m;
    srst = 1'b1;
    bus.wrreq_i = 0; bus.rdreq_i = 0; bus.flush_i = 0; bus.mode_i = 0; bus.err_clr_i = 0;
    wdata = '0;
    do_reset();
    cyc(0, 0, 0, 0, 0);
    // FIFO fill past full, full with simultaneous read/write, drain past empty
    repeat (17) cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    repeat (2)  cyc(1, 1, 0, 0, 0);
    repeat (17) cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    // mode request held off while data is stored
    repeat (5) cyc(1, 0, 0, 1, 0);
    repeat (5) cyc(0, 1, 0, 1, 0);
    repeat (2) cyc(0, 0, 0, 1, 0);
    // LIFO push/pop, then replace at depth 3
    repeat (4) cyc(1, 0, 0, 1, 0);
    repeat (4) cyc(0, 1, 0, 1, 0);
    repeat (3) cyc(1, 0, 0, 1, 0);
    cyc(1, 1, 0, 1, 0);
    repeat (3) cyc(0, 1, 0, 1, 0);
    // back to FIFO, overflow, drain to 9, flush, clear errors
    repeat (2) cyc(0, 0, 0, 0, 0);
    repeat (17) cyc(1, 0, 0, 0, 0);
    repeat (7) cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    // randomized traffic with drifting write/read bias
    m = 0; bias = 50; rbias = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 100 == 0) begin
        bias  = int'($urandom_range(10, 90));
        rbias = 100 - bias + int'($urandom_range(0, 10));
      end
      if ($urandom_range(0, 29) == 0) m = ~m;
      if (i == 1500) begin
        do_reset();
        m = 0;
      end
      cyc(($urandom_range(0, 99) < bias), ($urandom_range(0, 99) < rbias),
          ($urandom_range(0, 49) == 0), m, ($urandom_range(0, 19) == 0));
    end
    repeat (2) cyc(0, 0, 0, m, 0);
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
    @(negedge clk); #1;
    if (sb.size() > 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
